// File: rtl/fsk_codec_pkg.sv
// Shared types and helpers for the FSK tone encoder and decoder.
package fsk_codec_pkg;

  typedef enum logic [1:0] {
    ENC_IDLE = 2'd0,
    ENC_HIGH = 2'd1,
    ENC_LOW  = 2'd2
  } enc_state_t;

  typedef enum logic [1:0] {
    DEC_HUNT    = 2'd0,
    DEC_MEASURE = 2'd1,
    DEC_SKIP    = 2'd2
  } dec_state_t;

  // Tone half-period in clk cycles for symbol value s.
  function automatic int half_period(input int s, input int base_half, input int step_half);
    return base_half + s * step_half;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fsk_period_meter.sv
// Receive front end: two-flop synchroniser, either-edge detect and a
// saturating count of cycles since the last detected edge.
module fsk_period_meter
  import fsk_codec_pkg::*;
#(
  parameter int CNT_W        = 7,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_pulse,
  output logic             o_edge,
  output logic             o_rise,
  output logic [CNT_W-1:0] o_interval,
  output logic             o_timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(IDLE_TIMEOUT);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_prev;
  logic [CNT_W-1:0] r_cnt;
  logic             w_edge;

  assign w_edge     = r_sync2 ^ r_prev;
  assign o_edge     = w_edge;
  assign o_rise     = r_sync2 & ~r_prev;
  assign o_interval = r_cnt;
  assign o_timeout  = (r_cnt == TIMEOUT_C);

  // Synchronise, delay for edge compare, and restart the interval count on every edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_pulse;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_edge) begin
        r_cnt <= CNT_W'(1);
      end else if (r_cnt != TIMEOUT_C) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

endmodule

// File: rtl/fsk_codec.sv
// FSK codec: square-wave tone encoder plus a half-period classifying decoder
// that reports one symbol per PERIODS tone periods.
module fsk_codec
  import fsk_codec_pkg::*;
#(
  parameter int SYM_BITS     = 2,
  parameter int BASE_HALF    = 8,
  parameter int STEP_HALF    = 4,
  parameter int PERIODS      = 4,
  parameter int TOL          = 1,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic [SYM_BITS-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tone_out,
  input  logic                pulse_in,
  output logic [SYM_BITS-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_err
);

  localparam int NSYM     = 2 ** SYM_BITS;
  localparam int HALF_MAX = half_period(NSYM - 1, BASE_HALF, STEP_HALF);
  localparam int CNT_W    = $clog2(max2(IDLE_TIMEOUT, HALF_MAX + TOL) + 1);
  localparam int PER_W    = $clog2(PERIODS) + 1;
  localparam int RUN_W    = $clog2(2 * PERIODS) + 1;
  localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(2 * PERIODS - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS - 1);

  // ---------------- encoder ----------------
  enc_state_t       r_enc_state;
  logic             r_tone;
  logic             r_rdy_en;
  logic [CNT_W-1:0] r_half_cnt;
  logic [CNT_W-1:0] r_half_len;
  logic [PER_W-1:0] r_per_cnt;
  logic             w_xfer;
  logic             w_half_end;
  logic             w_last_per;

  assign tx_ready   = (r_enc_state == ENC_IDLE) & ena & r_rdy_en;
  assign w_xfer     = tx_valid & tx_ready;
  assign w_half_end = (r_half_cnt == r_half_len - CNT_W'(1));
  assign w_last_per = (r_per_cnt == PER_LAST);
  assign tone_out   = r_tone;

  // Encoder FSM: latch the symbol's half-period, then toggle for PERIODS full periods.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_enc_state <= ENC_IDLE;
      r_tone      <= 1'b0;
      r_rdy_en    <= 1'b0;
      r_half_cnt  <= '0;
      r_half_len  <= '0;
      r_per_cnt   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (!ena) begin
        r_enc_state <= ENC_IDLE;
        r_tone      <= 1'b0;
        r_half_cnt  <= '0;
        r_per_cnt   <= '0;
      end else begin
        case (r_enc_state)
          ENC_IDLE: begin
            if (w_xfer) begin
              r_enc_state <= ENC_HIGH;
              r_tone      <= 1'b1;
              r_half_cnt  <= '0;
              r_per_cnt   <= '0;
              r_half_len  <= CNT_W'(half_period(int'(tx_data), BASE_HALF, STEP_HALF));
            end else begin
              r_tone <= 1'b0;
            end
          end
          ENC_HIGH: begin
            if (w_half_end) begin
              r_enc_state <= ENC_LOW;
              r_tone      <= 1'b0;
              r_half_cnt  <= '0;
            end else begin
              r_half_cnt <= r_half_cnt + CNT_W'(1);
            end
          end
          ENC_LOW: begin
            if (w_half_end) begin
              r_half_cnt <= '0;
              if (w_last_per) begin
                r_enc_state <= ENC_IDLE;
                r_tone      <= 1'b0;
              end else begin
                r_enc_state <= ENC_HIGH;
                r_tone      <= 1'b1;
                r_per_cnt   <= r_per_cnt + PER_W'(1);
              end
            end else begin
              r_half_cnt <= r_half_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_enc_state <= ENC_IDLE;
            r_tone      <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------- decoder ----------------
  logic                w_edge;
  logic                w_rise;
  logic [CNT_W-1:0]    w_interval;
  logic                w_timeout;
  logic                w_match;
  logic [SYM_BITS-1:0] w_sym;
  logic [RUN_W-1:0]    w_run_nxt;

  dec_state_t          r_dec_state;
  logic [RUN_W-1:0]    r_run;
  logic [SYM_BITS-1:0] r_cand;
  logic [SYM_BITS-1:0] r_rx_data;
  logic                r_rx_valid;
  logic                r_rx_err;

  fsk_period_meter #(
    .CNT_W        (CNT_W),
    .IDLE_TIMEOUT (IDLE_TIMEOUT)
  ) u_meter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_pulse    (pulse_in),
    .o_edge     (w_edge),
    .o_rise     (w_rise),
    .o_interval (w_interval),
    .o_timeout  (w_timeout)
  );

  // Map the measured interval onto the symbol band it falls in, if any.
  always_comb begin
    w_match = 1'b0;
    w_sym   = '0;
    for (int s = 0; s < NSYM; s++) begin
      w_sym   = ((int'(w_interval) >= half_period(s, BASE_HALF, STEP_HALF) - TOL) &&
                 (int'(w_interval) <= half_period(s, BASE_HALF, STEP_HALF) + TOL)) ? SYM_BITS'(s) : w_sym;
      w_match = w_match |
                ((int'(w_interval) >= half_period(s, BASE_HALF, STEP_HALF) - TOL) &&
                 (int'(w_interval) <= half_period(s, BASE_HALF, STEP_HALF) + TOL));
    end
  end

  assign w_run_nxt = (w_sym == r_cand) ? (r_run + RUN_W'(1)) : RUN_W'(1);

  // Decoder FSM: a symbol is accepted once 2*PERIODS-1 consecutive intervals agree.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dec_state <= DEC_HUNT;
      r_run       <= '0;
      r_cand      <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_err    <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      if (!ena) begin
        r_dec_state <= DEC_HUNT;
        r_run       <= '0;
      end else begin
        case (r_dec_state)
          DEC_HUNT: begin
            r_run <= '0;
            if (w_rise) begin
              r_dec_state <= DEC_MEASURE;
            end else begin
              r_dec_state <= DEC_HUNT;
            end
          end
          DEC_MEASURE: begin
            if (w_timeout) begin
              r_dec_state <= DEC_HUNT;
              r_run       <= '0;
            end else if (w_edge) begin
              if (!w_match) begin
                r_rx_err <= 1'b1;
                r_run    <= '0;
              end else if (w_run_nxt == RUN_DONE) begin
                r_rx_valid  <= 1'b1;
                r_rx_data   <= w_sym;
                r_cand      <= w_sym;
                r_run       <= '0;
                r_dec_state <= DEC_SKIP;
              end else begin
                r_cand <= w_sym;
                r_run  <= w_run_nxt;
              end
            end else begin
              r_run <= r_run;
            end
          end
          // The gap after a completed symbol is one idle cycle longer than a half-period; drop it.
          DEC_SKIP: begin
            if (w_timeout) begin
              r_dec_state <= DEC_HUNT;
              r_run       <= '0;
            end else if (w_edge) begin
              r_dec_state <= DEC_MEASURE;
            end else begin
              r_dec_state <= DEC_SKIP;
            end
          end
          default: begin
            r_dec_state <= DEC_HUNT;
            r_run       <= '0;
          end
        endcase
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign rx_err   = r_rx_err;

endmodule

// File: tb/tb_fsk_codec.sv
// Directed bench for fsk_codec with tone_out looped to pulse_in and a queue of
// expected received symbols.
module tb_fsk_codec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [1:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tone_out;
  logic       pulse_in;
  logic [1:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       loop_en;
  logic       pulse_force;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int last_valid_cyc = -1;
  int t_xfer = 0;
  logic [1:0] exp_q[$];

  assign pulse_in = loop_en ? tone_out : pulse_force;

  always #5 clk = ~clk;

  fsk_codec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tone_out (tone_out),
    .pulse_in (pulse_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock, sampled 1 time unit after the rising edge; scoreboards any strobe.
  task automatic tick();
    logic [1:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid === 1'b1 || rx_err === 1'b1)
      check("strobe_exclusive", {31'd0, rx_valid & rx_err}, 32'd0);
    if (rx_valid === 1'b1) begin
      n_valid++;
      last_valid_cyc = cyc;
      check("rx_valid_expected", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rx_data", {30'd0, rx_data}, {30'd0, e});
      end
    end
    if (rx_err === 1'b1) n_err++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [1:0] s, input bit expect_rx);
    int w;
    w = 0;
    while (tx_ready !== 1'b1 && w < 400) begin
      tick();
      w++;
    end
    check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = s;
    tx_valid = 1'b1;
    t_xfer   = cyc;
    if (expect_rx) exp_q.push_back(s);
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() > 0 && w < 300) begin
      tick();
      w++;
    end
    idle(5);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int bad_t;
    int bad_r;
    int v0;
    int e0;
    rst_n = 1'b0;
    ena = 1'b1;
    tx_valid = 1'b0;
    tx_data = 2'd0;
    loop_en = 1'b1;
    pulse_force = 1'b0;

    // Reset for three cycles
    idle(3);
    check("rst_tone_out", {31'd0, tone_out}, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_rx_err", {31'd0, rx_err}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("ready_after_release", {31'd0, tx_ready}, 32'd1);

    // Symbol 2: 16 high / 16 low x4, decoded 3 cycles after the last falling edge
    e0 = n_err;
    send(2'd2, 1'b1);
    bad_t = 0;
    bad_r = 0;
    for (int i = 0; i < 128; i++) begin
      if (tone_out !== ((((i / 16) % 2) == 0) ? 1'b1 : 1'b0)) bad_t++;
      if (tx_ready !== 1'b0) bad_r++;
      tick();
    end
    check("sym2_tone_shape", bad_t, 32'd0);
    check("sym2_ready_low", bad_r, 32'd0);
    check("sym2_ready_back", {31'd0, tx_ready}, 32'd1);
    check("sym2_tone_idle", {31'd0, tone_out}, 32'd0);
    check("sym2_valid_cycle", last_valid_cyc, t_xfer + 1 + 7 * 16 + 3);
    check("sym2_decoded", exp_q.size(), 32'd0);
    check("sym2_no_err", n_err - e0, 32'd0);

    // Back-to-back 0,3,3,1
    v0 = n_valid;
    e0 = n_err;
    send(2'd0, 1'b1);
    send(2'd3, 1'b1);
    send(2'd3, 1'b1);
    send(2'd1, 1'b1);
    drain();
    check("b2b_valid_count", n_valid - v0, 32'd4);
    check("b2b_no_err", n_err - e0, 32'd0);
    idle(80);

    // Out-of-band 5-cycle half-periods: first rise arms, 9 following edges error
    v0 = n_valid;
    e0 = n_err;
    loop_en = 1'b0;
    pulse_force = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pulse_force = ~pulse_force;
      idle(5);
    end
    idle(10);
    check("badrate_err_count", n_err - e0, 32'd9);
    check("badrate_no_valid", n_valid - v0, 32'd0);
    loop_en = 1'b1;
    idle(80);

    // Static input mid-symbol times out silently; next symbol 1 decodes
    v0 = n_valid;
    e0 = n_err;
    send(2'd1, 1'b0);
    idle(30);
    pulse_force = tone_out;
    loop_en = 1'b0;
    idle(100);
    check("hold_no_valid", n_valid - v0, 32'd0);
    check("hold_no_err", n_err - e0, 32'd0);
    loop_en = 1'b1;
    pulse_force = 1'b0;
    idle(5);
    send(2'd1, 1'b1);
    drain();
    check("hold_recover_valid", n_valid - v0, 32'd1);
    check("hold_recover_no_err", n_err - e0, 32'd0);
    idle(80);

    // ena dropped mid-symbol 3
    v0 = n_valid;
    e0 = n_err;
    send(2'd3, 1'b0);
    idle(40);
    ena = 1'b0;
    tick();
    check("ena_tone_off", {31'd0, tone_out}, 32'd0);
    bad_r = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_ready !== 1'b0) bad_r++;
      if (tone_out !== 1'b0) bad_r++;
      tick();
    end
    check("ena_low_ready_tone", bad_r, 32'd0);
    ena = 1'b1;
    tick();
    check("ena_back_ready", {31'd0, tx_ready}, 32'd1);
    idle(80);
    check("ena_no_valid", n_valid - v0, 32'd0);
    check("ena_no_err", n_err - e0, 32'd0);

    // Reset mid-symbol: no strobes, then a clean symbol 0
    v0 = n_valid;
    e0 = n_err;
    send(2'd3, 1'b0);
    idle(50);
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_tone_off", {31'd0, tone_out}, 32'd0);
    check("midrst_ready_low", {31'd0, tx_ready}, 32'd0);
    rst_n = 1'b1;
    idle(80);
    check("midrst_no_valid", n_valid - v0, 32'd0);
    check("midrst_no_err", n_err - e0, 32'd0);
    send(2'd0, 1'b1);
    drain();
    check("final_valid_count", n_valid - v0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fsk_codec.md
FSK_CODEC -- requirements
Module: fsk_codec

Interface
REQ-001 Parameter SYM_BITS, default 2: symbol width; 2**SYM_BITS tones.
REQ-002 Parameter BASE_HALF, default 8: tone half-period for symbol 0, in clk cycles.
REQ-003 Parameter STEP_HALF, default 4: half-period increment per symbol value; half(s) = BASE_HALF + s*STEP_HALF.
REQ-004 Parameter PERIODS, default 4: full tone periods transmitted per symbol.
REQ-005 Parameter TOL, default 1: decoder acceptance window, +/- cycles on a half-period; legal only if 2*TOL < STEP_HALF.
REQ-006 Parameter IDLE_TIMEOUT, default 64: edge-free cycles before the decoder resynchronises; legal only if > half(max)+TOL+1.
REQ-007 clk input 1: single clock; all state on rising edge.
REQ-008 rst_n input 1: reset, synchronous, active-low.
REQ-009 ena input 1: block enable; low aborts both halves (see REQ-024).
REQ-010 tx_data input SYM_BITS: symbol to transmit.
REQ-011 tx_valid input 1: tx_data offered.
REQ-012 tx_ready output 1: encoder idle, accepts a symbol this cycle.
REQ-013 tone_out output 1: encoded square-wave tone.
REQ-014 pulse_in input 1: asynchronous received tone.
REQ-015 rx_data output SYM_BITS: last decoded symbol, held until next rx_valid.
REQ-016 rx_valid output 1: one-cycle strobe, rx_data new.
REQ-017 rx_err output 1: one-cycle strobe, half-period outside every band.

Function
REQ-018 Encoder FSM IDLE/HIGH/LOW; tx_ready = 1 only in IDLE and ena=1; transfer on tx_valid & tx_ready.
REQ-019 Transfer in cycle n: symbol latched, tone_out = 1 from cycle n+1 for half(s) cycles, then 0 for half(s) cycles, repeated PERIODS times; then IDLE with tone_out 0; tx_ready high again in cycle n+1+2*PERIODS*half(s).
REQ-020 tx_data is ignored outside a transfer; back-to-back transfers therefore leave one IDLE cycle (tone_out 0) between symbols.
REQ-021 Decoder: pulse_in through 2-flop synchroniser, then edge detect (either edge); half-period counter counts cycles between successive edges, saturating at IDLE_TIMEOUT.
REQ-022 Decoder FSM HUNT/MEASURE/SKIP. HUNT -> MEASURE on a synchronised rising edge (count cleared). In MEASURE each edge classifies the measured interval H: symbol s if |H - half(s)| <= TOL, else rx_err pulse and run counter cleared. Matching s equal to candidate increments run; differing s sets candidate = s, run = 1.
REQ-023 When run reaches 2*PERIODS-1: rx_valid pulse, rx_data = candidate, run cleared, state -> SKIP; the next edge's interval (inter-symbol gap) is discarded, no error, state -> MEASURE.
REQ-024 Counter reaching IDLE_TIMEOUT in MEASURE or SKIP -> HUNT, run cleared, no rx_err; ena = 0 forces encoder to IDLE (tone_out 0) and decoder to HUNT, strobes 0.
REQ-025 rx_valid/rx_err registered; rx_valid asserted 3 cycles after the pulse_in edge that completes the run; rx_valid and rx_err never both high.
REQ-026 Counter widths = $clog2(max(IDLE_TIMEOUT, half(2**SYM_BITS-1)+TOL)+1); no wrap.

Reset
REQ-027 rst_n = 0 at a clk edge: encoder IDLE, tone_out 0, tx_ready 0 during reset, 1 on first cycle after release if ena=1.
REQ-028 Reset: decoder HUNT, synchroniser flops 0, counters/run/candidate 0, rx_data 0, rx_valid 0, rx_err 0.
REQ-029 Reset mid-symbol aborts transmission and decode without any strobe.

Structure
REQ-030 Package fsk_codec_pkg holds encoder and decoder state enums and a function half_period(s) used by both halves.
REQ-031 Decoder synchroniser, edge detect and saturating interval counter live in one sub-module fsk_period_meter; the rest is in fsk_codec.

Verification (defaults, tone_out looped to pulse_in unless stated)
REQ-032 Reset 3 cycles with ena=1 -> tone_out 0, rx_valid 0, tx_ready 1 first cycle after release.
REQ-033 Send symbol 2 -> tone_out 16 high/16 low x4 (128 cycles), tx_ready low 128 cycles; rx_valid with rx_data 2 three cycles after the final falling edge.
REQ-034 Back-to-back 0,3,3,1 -> exactly four rx_valid strobes, data 0,3,3,1, no rx_err.
REQ-035 Drive pulse_in with 5-cycle half-periods -> rx_err on each classified edge, no rx_valid.
REQ-036 Hold pulse_in static 64 cycles mid-symbol -> decoder HUNT, no strobes; next clean symbol 1 decodes correctly.
REQ-037 Deassert ena mid-symbol 3 -> tone_out 0 next cycle, tx_ready 0 until ena returns, no rx_valid.
